pcs_scrambler_64: RTL and testbench
===================================

PCS_SCRAMBLER_64 -- requirements
Module: pcs_scrambler_64

Interface
REQ-001 SHALL have parameter SCR_SEED, default 58'h3FF_FFFF_FFFF_FFFF, the scrambler state loaded at reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port scr_enable  input  1  1 = scramble, 0 = bypass.
REQ-005 SHALL have port in_data  input  64  upstream 64-bit block, bit 0 transmitted first.
REQ-006 SHALL have port in_datavalid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_dataerror  input  1  error tag for in_data.
REQ-008 SHALL have port out_idle  output  1  to upstream: a word can be accepted this cycle.
REQ-009 SHALL have port out_data  output  64  scrambled word to the 64->48 gearbox.
REQ-010 SHALL have port out_datavalid  output  1  out_data valid, gearbox consumes it.
REQ-011 SHALL have port out_dataerror  output  1  error tag travelling with out_data.
REQ-012 SHALL have port in_idle  input  1  from gearbox: it can accept a 64-bit word this cycle.
REQ-013 SHALL have port overflow  output  1  sticky flag: write attempted while out_idle=0.

Function
REQ-014 SHALL accept a word when in_datavalid=1 and out_idle=1; accepted words are the only ones that are processed.
REQ-015 SHALL scramble with x^58+x^39+1, self-synchronous: s[i] = d[i] ^ s[i-39] ^ s[i-58], i=0..63, history being the 58 most recent scrambled bits.
REQ-016 SHALL update the 58-bit state to bits [63:6] of the scrambled word, and only on an accepted word while scr_enable=1.
REQ-017 SHALL pass accepted data unchanged and hold the state when scr_enable=0; scr_enable is sampled in the accept cycle.
REQ-018 SHALL scramble error-tagged words normally and carry in_dataerror unchanged alongside the word.
REQ-019 SHALL write each scrambled word and its error bit into a 2-entry FIFO in the accept cycle; one-cycle latency, so the earliest out_datavalid is the next cycle.
REQ-020 SHALL drive out_datavalid = FIFO non-empty AND in_idle, so out_datavalid is never 1 while in_idle=0.
REQ-021 SHALL pop the head entry in every cycle where out_datavalid=1.
REQ-022 SHALL drive out_data and out_dataerror from the FIFO head whenever it is non-empty; they are don't-care when it is empty.
REQ-023 SHALL register out_idle as 1 when FIFO count is 0, or count is 1 and no push occurs this cycle; it SHALL be 0 at count 2.
REQ-024 SHALL, when a push and a pop occur in the same cycle, keep the count unchanged and preserve FIFO order.
REQ-025 SHALL drop the word and set overflow when in_datavalid=1 while out_idle=0; FIFO and state are untouched, and overflow clears only on reset.
REQ-026 SHALL wrap the 1-bit read and write pointers modulo 2; count is 2 bits and saturates to no value beyond 2.

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge, load state=SCR_SEED, clear FIFO count and pointers, and clear overflow.
REQ-028 SHALL present out_idle=0 during reset and out_idle=1 in the first cycle after reset release; out_datavalid=0 and overflow=0 during reset.
REQ-029 SHALL discard FIFO contents on reset asserted mid-operation; no word is emitted after reset.

Structure
REQ-030 SHALL take the scrambler taps (39, 58), state width 58 and the default seed from the shared pcs25g package, which also holds the gearbox word sizes.
REQ-031 SHALL place the 2-entry FIFO in one sub-module, pcs_fifo2, parameterised by width (65 = data + error).
REQ-032 SHALL implement the scramble function as combinational logic within pcs_scrambler_64.

Verification
REQ-033 SHALL cover: reset, then one word 64'h0 with scr_enable=1 and in_idle=1 -> out_data=64'h03FF_FF80_0000_0000, out_datavalid=1 exactly one cycle after accept.
REQ-034 SHALL cover: scr_enable=0 and in_data=64'hDEAD_BEEF_0123_4567 -> out_data identical, state unchanged (next scrambled word matches a fresh-seed reference).
REQ-035 SHALL cover: in_idle held 0 while 3 words are offered -> 2 accepted, out_idle=0 at count 2, out_datavalid stays 0; after in_idle=1, words drain in order.
REQ-036 SHALL cover: a write while out_idle=0 -> overflow=1 stays set, dropped word never appears, and a later reset clears overflow.
REQ-037 SHALL cover: 1000 random words with random in_idle gaps, checked against a software descrambler -> zero mismatches; out_dataerror matches in_dataerror per word.
REQ-038 SHALL cover: reset asserted with 2 words queued -> out_datavalid=0 after reset and the next output is a fresh-seed scramble.

Source files
------------

// File: rtl/pcs25g_pkg.sv
// Shared 25G PCS constants: scrambler polynomial, seed, gearbox sizes.
// Also holds the FIFO entry layout used between scrambler and gearbox.
package pcs25g_pkg;

  localparam int SCR_W     = 58;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;

  localparam logic [SCR_W-1:0] SCR_SEED_DEF =
    58'h3FF_FFFF_FFFF_FFFF;

  localparam int GB_IN_W  = 64;
  localparam int GB_OUT_W = 48;

  typedef struct packed {
    logic               err;
    logic [GB_IN_W-1:0] data;
  } scr_word_t;

endpackage

// File: rtl/pcs_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers and a saturating count.
// Ports: push/wdata in, pop/rdata out, count and empty status.
module pcs_fifo2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);
  assign empty   = (count == 2'd0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push_ok) wptr <= ~wptr;
      if (pop_ok)  rptr <= ~rptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pcs_scrambler_64.sv
// 64-bit self-synchronous x^58+x^39+1 scrambler feeding the 64->48 gearbox.
// Ports: in_* upstream word, out_* to gearbox, out_idle/in_idle flow ctrl.
module pcs_scrambler_64
  import pcs25g_pkg::*;
#(
  parameter logic [SCR_W-1:0] SCR_SEED = SCR_SEED_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scr_enable,
  input  logic [GB_IN_W-1:0] in_data,
  input  logic               in_datavalid,
  input  logic               in_dataerror,
  output logic               out_idle,
  output logic [GB_IN_W-1:0] out_data,
  output logic               out_datavalid,
  output logic               out_dataerror,
  input  logic               in_idle,
  output logic               overflow
);

  localparam int XW = SCR_W + GB_IN_W;

  logic [SCR_W-1:0]   state;
  logic [GB_IN_W-1:0] scr;
  logic               idle_q;
  logic               accept;
  logic               drop;
  logic [1:0]         count;
  logic               empty;
  scr_word_t          wr_word;
  scr_word_t          rd_word;

  assign accept = in_datavalid && out_idle;
  assign drop   = in_datavalid && !out_idle;

  // x[SCR_W-1:0] is history, oldest bit at 0.
  // Output bit i sits at x[i+SCR_W], so taps
  // are simple backward offsets into x.
  always_comb begin
    logic [XW-1:0] x;
    x = '0;
    x[SCR_W-1:0] = state;
    for (int i = 0; i < GB_IN_W; i++) begin
      x[i+SCR_W] = in_data[i]
                 ^ x[i+SCR_W-SCR_TAP_A]
                 ^ x[i+SCR_W-SCR_TAP_B];
    end
    scr = x[XW-1:SCR_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= SCR_SEED;
      overflow <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      if (accept && scr_enable)
        state <= scr[GB_IN_W-1:GB_IN_W-SCR_W];
      if (drop)
        overflow <= 1'b1;
      // Conservative: a slot is promised only
      // when the FIFO cannot be full next cycle.
      idle_q <= (count == 2'd0)
             || (count == 2'd1 && !accept);
    end
  end

  // Held low while in reset, ready as soon as
  // reset is released.
  assign out_idle = idle_q && reset_n;

  assign wr_word.err  = in_dataerror;
  assign wr_word.data = scr_enable ? scr : in_data;

  pcs_fifo2 #(
    .W($bits(scr_word_t))
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (accept),
    .wdata  (wr_word),
    .pop    (out_datavalid),
    .rdata  (rd_word),
    .count  (count),
    .empty  (empty)
  );

  assign out_datavalid = !empty && in_idle;
  assign out_data      = rd_word.data;
  assign out_dataerror = rd_word.err;

endmodule

// File: tb/tb_pcs_scrambler_64.sv
// Directed + randomised bench for pcs_scrambler_64.
// Expected words come from a bit-serial reference scrambler/descrambler.
module tb_pcs_scrambler_64;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Z_SCR = 64'h03FF_FF80_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scr_enable;
  logic [63:0] in_data;
  logic        in_datavalid;
  logic        in_dataerror;
  logic        out_idle;
  logic [63:0] out_data;
  logic        out_datavalid;
  logic        out_dataerror;
  logic        in_idle;
  logic        overflow;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcs_scrambler_64 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .scr_enable   (scr_enable),
    .in_data      (in_data),
    .in_datavalid (in_datavalid),
    .in_dataerror (in_dataerror),
    .out_idle     (out_idle),
    .out_data     (out_data),
    .out_datavalid(out_datavalid),
    .out_dataerror(out_dataerror),
    .in_idle      (in_idle),
    .overflow     (overflow)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        en;
  } exp_t;

  exp_t exp_q[$];

  // t[57] is the newest transmitted bit, t[0] is 58 bits back.
  function automatic logic [63:0] ref_scr(
    input  logic [63:0] d,
    input  logic [57:0] h,
    output logic [57:0] hn
  );
    logic [63:0] s;
    logic [57:0] t;
    t = h;
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ t[19] ^ t[0];
      t = {s[i], t[57:1]};
    end
    hn = t;
    return s;
  endfunction

  function automatic logic [63:0] ref_descr(
    input  logic [63:0] s,
    input  logic [57:0] h,
    output logic [57:0] hn
  );
    logic [63:0] d;
    logic [57:0] t;
    t = h;
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ t[19] ^ t[0];
      t = {s[i], t[57:1]};
    end
    hn = t;
    return d;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_datavalid = 1'b0;
    tick();
    tick();
    chk("rst_out_idle", out_idle, 0);
    chk("rst_out_dv", out_datavalid, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", out_idle, 1);
  endtask

  task automatic send(
    input logic [63:0] d,
    input logic        err,
    input logic        en
  );
    in_data = d;
    in_dataerror = err;
    scr_enable = en;
    in_datavalid = 1'b1;
    #1;
    chk("acc_out_idle", out_idle, 1);
    chk("acc_cycle_dv", out_datavalid, 0);
    tick();
    in_datavalid = 1'b0;
    #1;
  endtask

  initial begin
    logic [57:0] h;
    logic [57:0] hn;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] got;
    exp_t        e;
    int          acc;
    int          cyc;

    reset_n = 1'b0;
    scr_enable = 1'b1;
    in_data = '0;
    in_datavalid = 1'b0;
    in_dataerror = 1'b0;
    in_idle = 1'b1;

    // zero word from seed, one-cycle latency
    do_reset();
    send(64'h0, 1'b0, 1'b1);
    chk("zero_dv", out_datavalid, 1);
    chk("zero_data", out_data, Z_SCR);
    chk("zero_err", out_dataerror, 0);
    tick();
    chk("zero_pop_dv", out_datavalid, 0);

    // bypass leaves state at the seed
    do_reset();
    send(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    chk("byp_dv", out_datavalid, 1);
    chk("byp_data", out_data, 64'hDEAD_BEEF_0123_4567);
    chk("byp_err", out_dataerror, 1);
    tick();
    send(64'h0, 1'b0, 1'b1);
    chk("byp_next_data", out_data, Z_SCR);
    tick();

    // backpressure, full FIFO, overflow
    do_reset();
    h = SEED;
    in_idle = 1'b0;
    scr_enable = 1'b1;
    in_dataerror = 1'b0;
    in_datavalid = 1'b1;
    in_data = 64'h0000_0000_0000_0001;
    e1 = ref_scr(in_data, h, hn);
    h = hn;
    #1;
    chk("bp_idle_w1", out_idle, 1);
    tick();
    in_data = 64'h0000_0000_0000_0002;
    e2 = ref_scr(in_data, h, hn);
    h = hn;
    in_dataerror = 1'b1;
    #1;
    chk("bp_idle_w2", out_idle, 1);
    chk("bp_dv_w2", out_datavalid, 0);
    tick();
    in_data = 64'hFFFF_0000_FFFF_0003;
    in_dataerror = 1'b0;
    #1;
    chk("bp_idle_full", out_idle, 0);
    chk("bp_dv_full", out_datavalid, 0);
    tick();
    in_datavalid = 1'b0;
    #1;
    chk("ovf_set", overflow, 1);
    chk("bp_dv_hold", out_datavalid, 0);
    chk("bp_idle_hold", out_idle, 0);
    in_idle = 1'b1;
    #1;
    chk("drain1_dv", out_datavalid, 1);
    chk("drain1_data", out_data, e1);
    chk("drain1_err", out_dataerror, 0);
    tick();
    chk("drain2_dv", out_datavalid, 1);
    chk("drain2_data", out_data, e2);
    chk("drain2_err", out_dataerror, 1);
    tick();
    chk("drain_empty", out_datavalid, 0);
    tick();
    chk("drain_idle", out_idle, 1);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // reset with two words queued
    in_idle = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
    send(64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
    chk("q2_idle", out_idle, 0);
    do_reset();
    in_idle = 1'b1;
    #1;
    chk("q2_flush_dv", out_datavalid, 0);
    send(64'h0, 1'b0, 1'b1);
    chk("q2_fresh_data", out_data, Z_SCR);
    tick();

    // random traffic against the descrambler
    do_reset();
    h = SEED;
    acc = 0;
    cyc = 0;
    while ((acc < 1000 || exp_q.size() > 0)
           && cyc < 30000) begin
      in_idle = ($urandom_range(0, 9) < 7);
      in_data = {$urandom, $urandom};
      in_dataerror = 1'($urandom_range(0, 1));
      scr_enable = ($urandom_range(0, 7) != 0);
      in_datavalid = (acc < 1000)
                  && ($urandom_range(0, 3) != 0)
                  && out_idle;
      #1;
      chk("rnd_dv_rule", out_datavalid,
          (exp_q.size() > 0) && in_idle);
      if (out_datavalid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.en) begin
          got = ref_descr(out_data, h, hn);
          h = hn;
        end else begin
          got = out_data;
        end
        chk("rnd_data", got, e.data);
        chk("rnd_err", out_dataerror, e.err);
      end
      if (in_datavalid) begin
        exp_q.push_back('{in_data, in_dataerror,
                          scr_enable});
        acc++;
      end
      tick();
      cyc++;
    end
    in_datavalid = 1'b0;
    chk("rnd_all_done",
        (acc == 1000) && (exp_q.size() == 0), 1);
    chk("rnd_no_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
